// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder shared types and helpers.
// Optional overflow output is enabled with SCA_OVF_EN.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sca_state_t;

  // Number of chunks per operand.
  function automatic int sca_nchunks(
    input int w,
    input int c
  );
    return (c > 0) ? (w / c) : 1;
  endfunction

  // Chunk index width, never narrower than one bit.
  function automatic int sca_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One full-adder bit cell: returns {carry, sum}.
  function automatic logic [1:0] sca_fa(
    input logic a,
    input logic b,
    input logic c
  );
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_rca.sv
// chunk_rca: combinational CHUNK-bit ripple-carry adder.
// Also exports the carry into the top bit for overflow detection.
module chunk_rca
  import seq_chunk_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb_in
);

  // Ripple the carry through a chain of full-adder cells, LSB first.
  always_comb begin
    logic c;
    c = ci;
    sum = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb_in = c;
      {c, sum[i]} = sca_fa(a[i], b[i], c);
    end
    co = c;
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per clock.
// Define SCA_OVF_EN to add the ovf (signed overflow) output.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = sca_nchunks(WIDTH, CHUNK);
  localparam int IW = sca_idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) ||
      ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  sca_state_t state_q;
  sca_state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             last;
  int               off;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] csum;
  logic             cco;
  logic             cmsb;

  assign last = (idx_q == LAST);

  // Select the operand chunk addressed by the chunk index.
  always_comb begin
    off = int'(idx_q) * CHUNK;
    ca  = a_q[off +: CHUNK];
    cb  = b_q[off +: CHUNK];
  end

  chunk_rca #(
    .CHUNK(CHUNK)
  ) u_rca (
    .a       (ca),
    .b       (cb),
    .ci      (carry_q),
    .sum     (csum),
    .co      (cco),
    .c_msb_in(cmsb)
  );

`ifndef SCA_OVF_EN
  logic unused_cmsb;
  assign unused_cmsb = cmsb;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and chunk-serial accumulation of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s       <= '0;
      cout    <= 1'b0;
`ifdef SCA_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            idx_q   <= '0;
          end
        end
        BUSY: begin
          s[off +: CHUNK] <= csum;
          carry_q         <= cco;
          if (last) begin
            idx_q <= '0;
            cout  <= cco;
`ifdef SCA_OVF_EN
            ovf   <= cmsb ^ cco;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench for seq_chunk_adder.
// Checks ovf too when SCA_OVF_EN is defined.
module tb_seq_chunk_adder;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;

  logic       in_valid8;
  logic [7:0] A8;
  logic [7:0] B8;
  logic       cin8;
  logic       sub8;
  logic       ir_a, ov_a, co_a;
  logic       ir_b, ov_b, co_b;
  logic [7:0] s_a, s_b;

`ifdef SCA_OVF_EN
  logic ovf, ovf_a, ovf_b;
`endif

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout)
`ifdef SCA_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) d8a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (ir_a),
    .A        (A8),
    .B        (B8),
    .cin      (cin8),
    .sub      (sub8),
    .out_valid(ov_a),
    .out_ready(1'b1),
    .s        (s_a),
    .cout     (co_a)
`ifdef SCA_OVF_EN
    ,
    .ovf      (ovf_a)
`endif
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) d8b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (ir_b),
    .A        (A8),
    .B        (B8),
    .cin      (cin8),
    .sub      (sub8),
    .out_valid(ov_b),
    .out_ready(1'b1),
    .s        (s_b),
    .cout     (co_b)
`ifdef SCA_OVF_EN
    ,
    .ovf      (ovf_b)
`endif
  );

  typedef struct {
    logic [15:0] es;
    logic        eco;
    logic        eov;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  vec_t vt[9] = '{
    '{16'h0001, 16'h0003, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h0002, 16'h0005, 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
    '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, hold stability, result on handoff.
  logic        prev_ov = 1'b0;
  logic [15:0] hold_s = '0;
  logic        hold_co = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - exp_q[0].acc), 32'(N));
      end
      if (out_valid && prev_ov) begin
        chk("hold_s", 32'(s), 32'(hold_s));
        chk("hold_cout", 32'(cout), 32'(hold_co));
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("s", 32'(s), 32'(e.es));
        chk("cout", 32'(cout), 32'(e.eco));
`ifdef SCA_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.eov));
`endif
      end
      hold_s  = s;
      hold_co = cout;
      prev_ov = out_valid;
    end
  end

  task automatic do_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ci,
    input logic        sb,
    input logic [15:0] es,
    input logic        eco,
    input logic        eov
  );
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      return;
    end
    A = a;
    B = b;
    cin = ci;
    sub = sb;
    in_valid = 1'b1;
    e.es = es;
    e.eco = eco;
    e.eov = eov;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'hDEAD;
    B = 16'hBEEF;
    cin = ~ci;
    sub = ~sb;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic p8(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       sb,
    input logic [7:0] es,
    input logic       eco,
    input logic       eov
  );
    int t, la, lb;
    logic [7:0] sa, sbv;
    logic coa, cob;
`ifdef SCA_OVF_EN
    logic ova, ovb;
`endif
    la = -1;
    lb = -1;
    sa = '0;
    sbv = '0;
    coa = 1'b0;
    cob = 1'b0;
`ifdef SCA_OVF_EN
    ova = 1'b0;
    ovb = 1'b0;
`endif
    t = 0;
    @(negedge clk);
    while (!(ir_a && ir_b) && t < 50) begin
      @(negedge clk);
      t++;
    end
    A8 = a;
    B8 = b;
    cin8 = 1'b0;
    sub8 = sb;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov_a && la < 0) begin
        la = i;
        sa = s_a;
        coa = co_a;
`ifdef SCA_OVF_EN
        ova = ovf_a;
`endif
      end
      if (ov_b && lb < 0) begin
        lb = i;
        sbv = s_b;
        cob = co_b;
`ifdef SCA_OVF_EN
        ovb = ovf_b;
`endif
      end
      if (la >= 0 && lb >= 0) break;
    end
    chk("w8c8_latency", 32'(la), 32'd1);
    chk("w8c1_latency", 32'(lb), 32'd8);
    chk("w8c8_s", 32'(sa), 32'(es));
    chk("w8c1_s", 32'(sbv), 32'(es));
    chk("w8c8_cout", 32'(coa), 32'(eco));
    chk("w8c1_cout", 32'(cob), 32'(eco));
`ifdef SCA_OVF_EN
    chk("w8c8_ovf", 32'(ova), 32'(eov));
    chk("w8c1_ovf", 32'(ovb), 32'(eov));
`endif
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    cin = 1'b0;
    sub = 1'b0;
    in_valid8 = 1'b0;
    A8 = '0;
    B8 = '0;
    cin8 = 1'b0;
    sub8 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SCA_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    foreach (vt[i])
      do_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb,
            vt[i].es, vt[i].eco, vt[i].eov);
    drain();

    // Backpressure: hold result for 10 cycles, poke ignored input.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    do_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      A = 16'h1234;
      B = 16'h1111;
      in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
    chk("bp_retain_s", 32'(s), 32'h0FFF);
    drain();

    // Reset while chunk 2 is in progress.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain();

    // Narrow configurations: single chunk and bit-serial.
    p8(8'hFD, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0);
    p8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
